fifo_rr_merger: RTL and testbench
=================================

Name: fifo_rr_merger

Overview:
- Egress-side counterpart of the transaction-layer 1-to-4 distributor.
- Drains four per-class FIFOs (class 0..3) in round-robin order and pushes every word into one shared output FIFO.
- Sits between the four class FIFOs and the output FIFO that feeds the next layer.
- Issues pops, realigns the returned data, and pushes it downstream, throttled by the output FIFO's almost_full.

Parameters:
- DATA_WIDTH, 12, width of each FIFO word.
- RESET_STATE, 4'b0001, encoding of the top-level state that forces a soft clear.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_L  in  1  asynchronous, active-low reset
- state  in  4  top-level FSM state; equal to RESET_STATE means soft clear
- empty_0..empty_3  in  1 each  class FIFO empty flags
- data_in_0..data_in_3  in  DATA_WIDTH each  class FIFO read data
- almost_full  in  1  output FIFO almost-full flag
- pop_0..pop_3  out  1 each  registered class FIFO pop strobes
- push  out  1  registered output FIFO push strobe
- data_out  out  DATA_WIDTH  registered write data, valid when push=1
- idle  out  1  high when nothing is in flight and all class FIFOs are empty

Behaviour:
- Reset (reset_L=0, asynchronous):
  - pop_0..3=0, push=0, data_out=0, idle=1.
  - Round-robin pointer=0; pipeline valid bits cleared.
- Soft clear (state==RESET_STATE, synchronous): same values as reset. In-flight words are discarded, not pushed.
- Class FIFO read contract:
  - Read data appears on data_in_k the cycle after the cycle in which pop_k=1.
  - empty_k reflects the pop by the following cycle.
- Grant stage (cycle N):
  - Precondition: almost_full=0 and at least one empty_k=0.
  - Grant the first non-empty class k, searching from ptr upward modulo 4.
  - Register pop_k=1 (exactly one pop high) and set ptr <= (k+1) mod 4.
  - If the precondition fails: all pops 0, ptr unchanged.
- One-hot pops: at most one pop_k high in any cycle. Never pop a class whose empty_k=1.
- Back-to-back pops of the same class are forbidden. If the class popped in the previous cycle is the only non-empty one, insert one bubble cycle before popping it again. This guards against empty_k lag.
- Capture stage (cycle N+1): pop_k is seen high; the selected index and a valid bit are delayed one cycle.
- Push stage (cycle N+2): data_out <= data_in_k registered, push=1. If nothing is valid, push=0 and data_out holds its last value.
- Latency: new pop to push is 2 cycles. Sustained throughput is 1 word/cycle when at least two classes are non-empty.
- Backpressure:
  - almost_full=1 blocks new pops only.
  - Up to 2 in-flight words are always pushed; the output FIFO's almost_full margin must be at least 2.
  - When almost_full drops, the grant resumes from the saved ptr.
- Fairness: each non-empty class is granted at least once per 4 grants.
- Pointer wrap: after granting class 3, ptr=0.
- idle = all empty_k=1 AND no pop high AND no word in the capture or push stage.

Decomposition:
- Shared package:
  - DATA_WIDTH default.
  - RESET_STATE encoding and the other top-level state encodings.
  - NUM_CLASSES=4 constant.
- Sub-module rr_grant4: combinational, no state.
  - Inputs: 4-bit request vector and 2-bit ptr.
  - Outputs: grant index and grant_valid.
  - Reused by any other 4-way arbiter in the layer.

Test Plan:
- Reset with all four FIFOs holding A0,B0,C0,D0, release reset_L -> pops fire in order 0,1,2,3 on consecutive cycles; push carries A0,B0,C0,D0, first push 2 cycles after pop_0.
- Only class 2 non-empty, depth 3 -> pop_2 high on alternate cycles only; pushes 3 words with a 1-cycle gap between them; idle=1 afterwards.
- ptr=3, classes 0 and 3 non-empty -> grant order 3,0,3,0; no pop of an empty class.
- Two pops in flight, then almost_full=1 -> exactly those 2 words pushed, no further pops; almost_full=0 -> resumes at the saved ptr.
- state=RESET_STATE mid-stream with 2 words in flight -> next cycle pops=0, push=0, data_out=0, ptr=0, no stale push afterwards.
- reset_L asserted between clock edges -> all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_rr_merger_pkg.sv
// Shared definitions for the egress round-robin merger.
// Holds the default word width, the number of class FIFOs and the
// top-level FSM state encodings (one of which requests a soft clear).
package fifo_rr_merger_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 12;
  localparam int unsigned NUM_CLASSES    = 4;

  typedef enum logic [3:0] {
    TOP_RESET  = 4'b0001,
    TOP_INIT   = 4'b0010,
    TOP_IDLE   = 4'b0100,
    TOP_ACTIVE = 4'b1000
  } top_state_e;

  localparam logic [3:0] RESET_STATE_ENC = TOP_RESET;

endpackage

// File: rtl/fifo_rr_merger_if.sv
// Bundle between the merger, the four class FIFOs and the output FIFO.
//   empty_k / data_in_k : class FIFO status and read data (into merger)
//   almost_full         : output FIFO fill flag (into merger)
//   pop_k               : class FIFO pop strobes (from merger)
//   push / data_out     : output FIFO write (from merger)
//   idle                : merger has nothing in flight, all classes empty
// slave  = merger side, master = FIFO/environment side.
interface fifo_rr_merger_if #(
  parameter int unsigned DATA_WIDTH = fifo_rr_merger_pkg::DEF_DATA_WIDTH
);
  logic                  empty_0, empty_1, empty_2, empty_3;
  logic [DATA_WIDTH-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic                  almost_full;
  logic                  pop_0, pop_1, pop_2, pop_3;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  idle;

  modport slave (
    input  empty_0, empty_1, empty_2, empty_3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  almost_full,
    output pop_0, pop_1, pop_2, pop_3,
    output push, data_out, idle
  );

  modport master (
    output empty_0, empty_1, empty_2, empty_3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output almost_full,
    input  pop_0, pop_1, pop_2, pop_3,
    input  push, data_out, idle
  );
endinterface

// File: rtl/fifo_rr_merger_grant.sv
// rr_grant4: combinational 4-way round-robin arbiter.
//   req_i       : request vector, bit k = requester k
//   ptr_i       : highest-priority index; search runs ptr_i upward mod 4
//   gnt_idx_o   : index of the first requester found
//   gnt_valid_o : at least one request present
module rr_grant4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_i + i[1:0];
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_idx_o   = cand;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_merger.sv
// fifo_rr_merger: drains four class FIFOs round-robin into one output FIFO.
// Pipeline: grant (registers pop_k) -> capture (index/valid delayed while
// the class FIFO returns data) -> push (registers data_out, push).
//   clk     : system clock
//   reset_L : asynchronous active-low reset
//   state   : top-level FSM state; RESET_STATE forces a synchronous clear
//   bus     : class FIFO / output FIFO handshake bundle (slave side)
module fifo_rr_merger
  import fifo_rr_merger_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [3:0]  RESET_STATE = RESET_STATE_ENC
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] state,
  fifo_rr_merger_if.slave bus
);

  logic [NUM_CLASSES-1:0] empty_v;
  logic [NUM_CLASSES-1:0] req;
  logic [1:0]             gnt_idx;
  logic                   gnt_valid;
  logic                   soft_clr;
  logic [DATA_WIDTH-1:0]  sel_data;

  logic [1:0]             ptr_q, ptr_d;
  logic [NUM_CLASSES-1:0] pop_q, pop_d;
  logic [1:0]             pop_idx_q, pop_idx_d;
  logic                   cap_valid_q, cap_valid_d;
  logic [1:0]             cap_idx_q, cap_idx_d;
  logic                   push_q, push_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   idle_q, idle_d;

  assign empty_v  = {bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};
  assign soft_clr = (state == RESET_STATE);

  // The class popped this cycle still shows its pre-pop empty flag, so it
  // is masked out; this alone yields the one-cycle bubble when it is the
  // only non-empty class, and never changes the winner otherwise because
  // the pointer already sits just past it.
  assign req = ~empty_v & ~pop_q;

  rr_grant4 u_grant (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    sel_data = bus.data_in_0;
    case (cap_idx_q)
      2'd0:    sel_data = bus.data_in_0;
      2'd1:    sel_data = bus.data_in_1;
      2'd2:    sel_data = bus.data_in_2;
      default: sel_data = bus.data_in_3;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    pop_d       = '0;
    pop_idx_d   = pop_idx_q;
    cap_valid_d = |pop_q;
    cap_idx_d   = pop_idx_q;
    push_d      = cap_valid_q;
    data_out_d  = cap_valid_q ? sel_data : data_out_q;

    if (gnt_valid && !bus.almost_full) begin
      pop_d[gnt_idx] = 1'b1;
      pop_idx_d      = gnt_idx;
      ptr_d          = gnt_idx + 2'd1;
    end

    // Registered idle: uses next-cycle pipeline contents with this cycle's
    // empty flags, so it settles one cycle after the last push.
    idle_d = (&empty_v) && !(|pop_d) && !cap_valid_d && !push_d;

    if (soft_clr) begin
      ptr_d       = '0;
      pop_d       = '0;
      pop_idx_d   = '0;
      cap_valid_d = 1'b0;
      cap_idx_d   = '0;
      push_d      = 1'b0;
      data_out_d  = '0;
      idle_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q       <= '0;
      pop_q       <= '0;
      pop_idx_q   <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      push_q      <= 1'b0;
      data_out_q  <= '0;
      idle_q      <= 1'b1;
    end else begin
      ptr_q       <= ptr_d;
      pop_q       <= pop_d;
      pop_idx_q   <= pop_idx_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      push_q      <= push_d;
      data_out_q  <= data_out_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.pop_0    = pop_q[0];
  assign bus.pop_1    = pop_q[1];
  assign bus.pop_2    = pop_q[2];
  assign bus.pop_3    = pop_q[3];
  assign bus.push     = push_q;
  assign bus.data_out = data_out_q;
  assign bus.idle     = idle_q;

endmodule

// File: tb/tb_fifo_rr_merger.sv
module tb_fifo_rr_merger;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [3:0]    state;
  logic          af;
  int            total = 0;
  int            bad   = 0;
  int            viol  = 0;
  int            cyc   = 0;

  fifo_rr_merger_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rr_merger #(.DATA_WIDTH(DW), .RESET_STATE(4'b0001)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .state   (state),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Class FIFO models: registered read data, empty updates after the pop.
  logic [DW-1:0] mem [4][16];
  int unsigned   wp [4];
  int unsigned   rp [4];
  logic [DW-1:0] din [4];
  logic [3:0]    pop_v;

  assign pop_v = {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0};
  assign bus.empty_0 = (rp[0] == wp[0]);
  assign bus.empty_1 = (rp[1] == wp[1]);
  assign bus.empty_2 = (rp[2] == wp[2]);
  assign bus.empty_3 = (rp[3] == wp[3]);
  assign bus.data_in_0 = din[0];
  assign bus.data_in_1 = din[1];
  assign bus.data_in_2 = din[2];
  assign bus.data_in_3 = din[3];
  assign bus.almost_full = af;

  initial begin
    for (int k = 0; k < 4; k++) begin
      wp[k] = 0;
      rp[k] = 0;
      din[k] = '0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if ($countones(pop_v) > 1) viol = viol + 1;
    for (int k = 0; k < 4; k++) begin
      if (pop_v[k]) begin
        if (rp[k] == wp[k]) viol = viol + 1;
        else begin
          din[k] <= mem[k][rp[k] % 16];
          rp[k]  <= rp[k] + 1;
        end
      end
    end
  end

  // Activity logs sampled away from the clock edge.
  int      pop_cls[$];
  int      pop_cyc[$];
  int      push_dat[$];
  int      push_cyc[$];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (pop_v[k]) begin
        pop_cls.push_back(k);
        pop_cyc.push_back(cyc);
      end
    end
    if (bus.push) begin
      push_dat.push_back(int'(bus.data_out));
      push_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_cls.delete();
    pop_cyc.delete();
    push_dat.delete();
    push_cyc.delete();
  endtask

  task automatic load(input int k, input logic [DW-1:0] v);
    mem[k][wp[k] % 16] = v;
    wp[k] = wp[k] + 1;
  endtask

  task automatic test_reset();
    int exp_d [4] = '{'hA00, 'hB00, 'hC00, 'hD00};
    step(2);
    load(0, 12'hA00); load(1, 12'hB00); load(2, 12'hC00); load(3, 12'hD00);
    total++; if (pop_v !== 4'b0000) begin bad++; $display("FAIL reset_pops got=%b exp=0000", pop_v); end
    total++; if (bus.push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", bus.push); end
    total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", bus.data_out); end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
    clear_logs();
    reset_L = 1'b1;
    step(12);
    total++; if (pop_cls.size() != 4 || push_dat.size() != 4) begin bad++;
      $display("FAIL rst_counts pops=%0d pushes=%0d exp=4/4", pop_cls.size(), push_dat.size()); end
    for (int i = 0; i < 4 && i < pop_cls.size() && i < push_dat.size(); i++) begin
      total++; if (pop_cls[i] != i) begin bad++; $display("FAIL rst_order[%0d] got=%0d exp=%0d", i, pop_cls[i], i); end
      total++; if (push_dat[i] != exp_d[i]) begin bad++; $display("FAIL rst_data[%0d] got=%h exp=%h", i, push_dat[i], exp_d[i]); end
      total++; if (push_cyc[i] - pop_cyc[i] != 2) begin bad++; $display("FAIL rst_latency[%0d] got=%0d exp=2", i, push_cyc[i] - pop_cyc[i]); end
      if (i > 0) begin
        total++; if (pop_cyc[i] - pop_cyc[i-1] != 1) begin bad++; $display("FAIL rst_b2b[%0d] got=%0d exp=1", i, pop_cyc[i] - pop_cyc[i-1]); end
      end
    end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL rst_idle_end got=%b exp=1", bus.idle); end
    total++; if (viol != 0) begin bad++; $display("FAIL rst_protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_single_class();
    int exp_d [3] = '{'h2A1, 'h2A2, 'h2A3};
    clear_logs();
    load(2, 12'h2A1); load(2, 12'h2A2); load(2, 12'h2A3);
    step(14);
    total++; if (pop_cls.size() != 3 || push_dat.size() != 3) begin bad++;
      $display("FAIL single_counts pops=%0d pushes=%0d exp=3/3", pop_cls.size(), push_dat.size()); end
    for (int i = 0; i < 3 && i < pop_cls.size() && i < push_dat.size(); i++) begin
      total++; if (pop_cls[i] != 2) begin bad++; $display("FAIL single_cls[%0d] got=%0d exp=2", i, pop_cls[i]); end
      total++; if (push_dat[i] != exp_d[i]) begin bad++; $display("FAIL single_data[%0d] got=%h exp=%h", i, push_dat[i], exp_d[i]); end
      if (i > 0) begin
        total++; if (pop_cyc[i] - pop_cyc[i-1] != 2) begin bad++; $display("FAIL single_popgap[%0d] got=%0d exp=2", i, pop_cyc[i] - pop_cyc[i-1]); end
        total++; if (push_cyc[i] - push_cyc[i-1] != 2) begin bad++; $display("FAIL single_pushgap[%0d] got=%0d exp=2", i, push_cyc[i] - push_cyc[i-1]); end
      end
    end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", bus.idle); end
    total++; if (viol != 0) begin bad++; $display("FAIL single_protocol got=%0d exp=0", viol); end
  endtask

  // Pointer sits at 3 after the previous scenario granted class 2.
  task automatic test_wrap();
    int exp_c [4] = '{3, 0, 3, 0};
    int exp_d [4] = '{'h3A1, 'h0A1, 'h3A2, 'h0A2};
    clear_logs();
    load(0, 12'h0A1); load(0, 12'h0A2); load(3, 12'h3A1); load(3, 12'h3A2);
    step(12);
    total++; if (pop_cls.size() != 4 || push_dat.size() != 4) begin bad++;
      $display("FAIL wrap_counts pops=%0d pushes=%0d exp=4/4", pop_cls.size(), push_dat.size()); end
    for (int i = 0; i < 4 && i < pop_cls.size() && i < push_dat.size(); i++) begin
      total++; if (pop_cls[i] != exp_c[i]) begin bad++; $display("FAIL wrap_order[%0d] got=%0d exp=%0d", i, pop_cls[i], exp_c[i]); end
      total++; if (push_dat[i] != exp_d[i]) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, push_dat[i], exp_d[i]); end
    end
    total++; if (viol != 0) begin bad++; $display("FAIL wrap_protocol got=%0d exp=0", viol); end
  endtask

  // Pointer is at 1 here.
  task automatic test_backpressure();
    int exp_c1 [2] = '{1, 2};
    int exp_d1 [2] = '{'h1B1, 'h2B1};
    int exp_c2 [2] = '{3, 1};
    int exp_d2 [2] = '{'h3B1, 'h1B2};
    clear_logs();
    load(1, 12'h1B1); load(1, 12'h1B2); load(2, 12'h2B1); load(3, 12'h3B1);
    step(2);
    af = 1'b1;
    step(8);
    total++; if (pop_cls.size() != 2 || push_dat.size() != 2) begin bad++;
      $display("FAIL bp_counts pops=%0d pushes=%0d exp=2/2", pop_cls.size(), push_dat.size()); end
    for (int i = 0; i < 2 && i < pop_cls.size() && i < push_dat.size(); i++) begin
      total++; if (pop_cls[i] != exp_c1[i]) begin bad++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, pop_cls[i], exp_c1[i]); end
      total++; if (push_dat[i] != exp_d1[i]) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, push_dat[i], exp_d1[i]); end
    end
    clear_logs();
    af = 1'b0;
    step(10);
    total++; if (pop_cls.size() != 2 || push_dat.size() != 2) begin bad++;
      $display("FAIL resume_counts pops=%0d pushes=%0d exp=2/2", pop_cls.size(), push_dat.size()); end
    for (int i = 0; i < 2 && i < pop_cls.size() && i < push_dat.size(); i++) begin
      total++; if (pop_cls[i] != exp_c2[i]) begin bad++; $display("FAIL resume_order[%0d] got=%0d exp=%0d", i, pop_cls[i], exp_c2[i]); end
      total++; if (push_dat[i] != exp_d2[i]) begin bad++; $display("FAIL resume_data[%0d] got=%h exp=%h", i, push_dat[i], exp_d2[i]); end
    end
    total++; if (viol != 0) begin bad++; $display("FAIL bp_protocol got=%0d exp=0", viol); end
  endtask

  // Pointer is at 2 here; soft clear must return it to 0.
  task automatic test_soft_clear();
    int exp_c [3] = '{0, 1, 0};
    int exp_d [3] = '{'h0C2, 'h1C2, 'h0C3};
    load(0, 12'h0C1); load(0, 12'h0C2); load(0, 12'h0C3);
    load(1, 12'h1C1); load(1, 12'h1C2);
    step(2);
    state = 4'b0001;
    step(1);
    total++; if (pop_v !== 4'b0000) begin bad++; $display("FAIL sclr_pops got=%b exp=0000", pop_v); end
    total++; if (bus.push !== 1'b0) begin bad++; $display("FAIL sclr_push got=%b exp=0", bus.push); end
    total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL sclr_data got=%h exp=000", bus.data_out); end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL sclr_idle got=%b exp=1", bus.idle); end
    clear_logs();
    step(1);
    state = 4'b1000;
    step(12);
    total++; if (pop_cls.size() != 3 || push_dat.size() != 3) begin bad++;
      $display("FAIL sclr_counts pops=%0d pushes=%0d exp=3/3", pop_cls.size(), push_dat.size()); end
    for (int i = 0; i < 3 && i < pop_cls.size() && i < push_dat.size(); i++) begin
      total++; if (pop_cls[i] != exp_c[i]) begin bad++; $display("FAIL sclr_order[%0d] got=%0d exp=%0d", i, pop_cls[i], exp_c[i]); end
      total++; if (push_dat[i] != exp_d[i]) begin bad++; $display("FAIL sclr_data[%0d] got=%h exp=%h", i, push_dat[i], exp_d[i]); end
    end
    total++; if (viol != 0) begin bad++; $display("FAIL sclr_protocol got=%0d exp=0", viol); end
  endtask

  // Pointer is at 1: grants go 3, 0, then a bubble for class 0.
  task automatic test_async_reset();
    load(0, 12'h0E1); load(0, 12'h0E2); load(3, 12'h3E3);
    step(3);
    total++; if (bus.push !== 1'b1 || bus.data_out !== 12'h3E3) begin bad++;
      $display("FAIL areset_pre push=%b data=%h exp=1/3e3", bus.push, bus.data_out); end
    #1 reset_L = 1'b0;
    #1;
    total++; if (pop_v !== 4'b0000) begin bad++; $display("FAIL areset_pops got=%b exp=0000", pop_v); end
    total++; if (bus.push !== 1'b0) begin bad++; $display("FAIL areset_push got=%b exp=0", bus.push); end
    total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL areset_data got=%h exp=000", bus.data_out); end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL areset_idle got=%b exp=1", bus.idle); end
    step(1);
    clear_logs();
    reset_L = 1'b1;
    step(10);
    total++; if (push_dat.size() != 1) begin bad++; $display("FAIL areset_count got=%0d exp=1", push_dat.size()); end
    else begin
      total++; if (push_dat[0] != 'h0E2) begin bad++; $display("FAIL areset_rest got=%h exp=0e2", push_dat[0]); end
    end
    total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL areset_idle_end got=%b exp=1", bus.idle); end
    total++; if (viol != 0) begin bad++; $display("FAIL areset_protocol got=%0d exp=0", viol); end
  endtask

  initial begin
    reset_L = 1'b0;
    state   = 4'b1000;
    af      = 1'b0;
    test_reset();
    test_single_class();
    test_wrap();
    test_backpressure();
    test_soft_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
